// File: rtl/turbosim_eq_pkg.sv
// rtl/turbosim_eq_pkg.sv - shared Event Queue opcodes, dispatcher states and TIME-field helper
// Contents:
//   EQ_OP_WR / EQ_OP_RD   values driven on the EQ op line
//   disp_state_e          dispatcher FSM states
//   ev_time_field()       extracts the TIME field [hi:lo] of an entry, zero-extended
package turbosim_eq_pkg;

  localparam logic EQ_OP_WR = 1'b1;
  localparam logic EQ_OP_RD = 1'b0;

  // Widest entry the helper handles; callers zero-extend into it and truncate the result.
  localparam int EQ_MAX_WD = 64;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    WAIT_DV = 3'd3,
    HOLD    = 3'd4
  } disp_state_e;

  function automatic logic [EQ_MAX_WD-1:0] ev_time_field(input logic [EQ_MAX_WD-1:0] ev,
                                                         input int hi, input int lo);
    logic [EQ_MAX_WD-1:0] mask;
    if (hi - lo + 1 >= EQ_MAX_WD) mask = '1;
    else                          mask = (EQ_MAX_WD'(1) << (hi - lo + 1)) - EQ_MAX_WD'(1);
    return (ev >> lo) & mask;
  endfunction

endpackage

// File: rtl/eq_dv_watchdog.sv
// rtl/eq_dv_watchdog.sv - counts cycles spent waiting for EQ dv and flags a timeout
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   armed_i        high while the dispatcher waits for dv; low clears the count
//   dv_i           EQ data-valid
//   expired_o      combinational: last allowed wait cycle passed without dv
module eq_dv_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic armed_i,
  input  logic dv_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the index of the current wait cycle (0 on the first one), so
  // expiry fires on the TIMEOUT-th cycle without dv.
  always_comb begin
    cnt_d = '0;
    if (armed_i && cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
  end

  assign expired_o = armed_i && !dv_i && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/event_dispatcher.sv
// rtl/event_dispatcher.sv - Event Queue initiator: inserts evaluator events, pops min-time events, tracks sim time
// Optional feature macro: EVDISP_DV_TIMEOUT_EN (abandon a read whose dv never arrives)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   run                      enables issuing new reads
//   ins_valid/ins_data/ins_ready     insert handshake from evaluators
//   disp_valid/disp_data/disp_ready  dispatch handshake to downstream
//   sim_time                 current simulation time (TIME field width)
//   done                     idle, queue empty, nothing pending or held
//   err                      sticky causality / timeout error
//   eq_cs/eq_op/eq_ev_in     command to the Event Queue
//   eq_ev_out/eq_dv          read data from the Event Queue
//   eq_full/eq_empty/eq_busy_rd/eq_busy_wr  Event Queue status
module event_dispatcher
  import turbosim_eq_pkg::*;
#(
  parameter int data_wd    = 32,
  parameter int hi         = 15,
  parameter int lo         = 0,
  parameter int DV_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               ins_valid,
  input  logic [data_wd-1:0] ins_data,
  output logic               ins_ready,
  output logic               disp_valid,
  output logic [data_wd-1:0] disp_data,
  input  logic               disp_ready,
  output logic [hi-lo:0]     sim_time,
  output logic               done,
  output logic               err,
  output logic [data_wd-1:0] eq_ev_in,
  output logic               eq_op,
  output logic               eq_cs,
  input  logic [data_wd-1:0] eq_ev_out,
  input  logic               eq_dv,
  input  logic               eq_full,
  input  logic               eq_empty,
  input  logic               eq_busy_rd,
  input  logic               eq_busy_wr
);
  localparam int TW = hi - lo + 1;

  disp_state_e        state_q, state_d;
  logic               eq_cs_q, eq_cs_d;
  logic               eq_op_q, eq_op_d;
  logic [data_wd-1:0] eq_ev_in_q, eq_ev_in_d;
  logic               ins_ready_q, ins_ready_d;
  logic               disp_valid_q, disp_valid_d;
  logic [data_wd-1:0] disp_data_q, disp_data_d;
  logic [TW-1:0]      sim_time_q, sim_time_d;
  logic               err_q, err_d;
  logic               done_q, done_d;

  logic [TW-1:0]      ins_t, ev_t;
  logic               dv_timeout;

  assign ins_t = TW'(ev_time_field(EQ_MAX_WD'(ins_data), hi, lo));
  assign ev_t  = TW'(ev_time_field(EQ_MAX_WD'(eq_ev_out), hi, lo));

`ifdef EVDISP_DV_TIMEOUT_EN
  eq_dv_watchdog #(.TIMEOUT(DV_TIMEOUT)) u_dv_watchdog (
    .clk_i     (clk),
    .rst_i     (rst),
    .armed_i   (state_q == WAIT_DV),
    .dv_i      (eq_dv),
    .expired_o (dv_timeout)
  );
`else
  assign dv_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    eq_cs_d      = 1'b0;
    eq_op_d      = eq_op_q;
    eq_ev_in_d   = eq_ev_in_q;
    ins_ready_d  = 1'b0;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    sim_time_d   = sim_time_q;
    err_d        = err_q;
    done_d       = (state_q == IDLE) && eq_empty && !ins_valid && !disp_valid_q;

    // Outputs are registered, so the command for WR/RD is loaded on the
    // transition into that state and is visible for exactly its one cycle.
    case (state_q)
      IDLE: begin
        if (ins_valid && !eq_full && !eq_busy_wr) begin
          state_d     = WR;
          eq_cs_d     = 1'b1;
          eq_op_d     = EQ_OP_WR;
          eq_ev_in_d  = ins_data;
          ins_ready_d = 1'b1;
          // Scheduling into the past breaks causality; flag it but still insert.
          if (ins_t < sim_time_q) err_d = 1'b1;
        end else if (run && !eq_empty && !eq_busy_rd && !disp_valid_q) begin
          state_d = RD;
          eq_cs_d = 1'b1;
          eq_op_d = EQ_OP_RD;
        end
      end
      WR:      state_d = IDLE;
      RD:      state_d = WAIT_DV;
      WAIT_DV: begin
        if (eq_dv) begin
          disp_data_d  = eq_ev_out;
          disp_valid_d = 1'b1;
          if (ev_t > sim_time_q) sim_time_d = ev_t;
          if (ev_t < sim_time_q) err_d = 1'b1;
          state_d = HOLD;
        end else if (dv_timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (disp_ready) begin
          disp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      eq_cs_q      <= 1'b0;
      eq_op_q      <= 1'b0;
      eq_ev_in_q   <= '0;
      ins_ready_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      sim_time_q   <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      eq_cs_q      <= eq_cs_d;
      eq_op_q      <= eq_op_d;
      eq_ev_in_q   <= eq_ev_in_d;
      ins_ready_q  <= ins_ready_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      sim_time_q   <= sim_time_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  assign eq_cs      = eq_cs_q;
  assign eq_op      = eq_op_q;
  assign eq_ev_in   = eq_ev_in_q;
  assign ins_ready  = ins_ready_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign sim_time   = sim_time_q;
  assign err        = err_q;
  assign done       = done_q;

endmodule

// File: tb/tb_event_dispatcher.sv
// tb/tb_event_dispatcher.sv - directed self-checking bench for event_dispatcher with a behavioural Event Queue
module tb_event_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic        ins_ready;
  logic        disp_valid;
  logic [31:0] disp_data;
  logic        disp_ready;
  logic [15:0] sim_time;
  logic        done;
  logic        err;
  logic [31:0] eq_ev_in;
  logic        eq_op;
  logic        eq_cs;
  logic [31:0] eq_ev_out;
  logic        eq_dv;
  logic        eq_full;
  logic        eq_empty;
  logic        eq_busy_rd;
  logic        eq_busy_wr;

  int total = 0;
  int bad   = 0;

  logic full_force = 1'b0;
  logic withhold   = 1'b0;

  event_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .ins_valid  (ins_valid),
    .ins_data   (ins_data),
    .ins_ready  (ins_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready),
    .sim_time   (sim_time),
    .done       (done),
    .err        (err),
    .eq_ev_in   (eq_ev_in),
    .eq_op      (eq_op),
    .eq_cs      (eq_cs),
    .eq_ev_out  (eq_ev_out),
    .eq_dv      (eq_dv),
    .eq_full    (eq_full),
    .eq_empty   (eq_empty),
    .eq_busy_rd (eq_busy_rd),
    .eq_busy_wr (eq_busy_wr)
  );

  always #5 clk = ~clk;

  // Behavioural Event Queue: pops the minimum TIME entry, dv one cycle after the read.
  logic [31:0] evq[$];
  logic        rd_pend;
  logic [31:0] pend_data;

  assign eq_full    = full_force;
  assign eq_busy_rd = 1'b0;
  assign eq_busy_wr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      evq.delete();
      eq_empty  <= 1'b1;
      eq_dv     <= 1'b0;
      eq_ev_out <= '0;
      rd_pend   <= 1'b0;
    end else begin
      eq_dv <= 1'b0;
      if (rd_pend && !withhold) begin
        eq_dv     <= 1'b1;
        eq_ev_out <= pend_data;
        rd_pend   <= 1'b0;
      end
      if (eq_cs && eq_op) begin
        evq.push_back(eq_ev_in);
      end else if (eq_cs && !eq_op && evq.size() > 0) begin
        int m;
        m = 0;
        for (int i = 1; i < evq.size(); i++)
          if (evq[i][15:0] < evq[m][15:0]) m = i;
        pend_data = evq[m];
        evq.delete(m);
        rd_pend <= 1'b1;
      end
      eq_empty <= (evq.size() == 0);
    end
  end

  task automatic do_insert(input logic [31:0] d, output bit got,
                           output logic [1:0] cs_op, output logic [31:0] ev);
    got = 0;
    cs_op = 2'b00;
    ev = '0;
    ins_valid = 1'b1;
    ins_data  = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ins_ready === 1'b1) begin
        got = 1;
        cs_op = {eq_cs, eq_op};
        ev = eq_ev_in;
      end
    end
    ins_valid = 1'b0;
  endtask

  task automatic wait_disp(output bit got);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (disp_valid === 1'b1) got = 1;
    end
  endtask

  task automatic accept();
    disp_ready = 1'b1;
    @(negedge clk);
    disp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({eq_cs, eq_op, ins_ready, disp_valid, err, done} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {eq_cs, eq_op, ins_ready, disp_valid, err, done});
    end
    total++;
    if (eq_ev_in !== 32'h0 || disp_data !== 32'h0 || sim_time !== 16'h0) begin
      bad++; $display("FAIL reset_data got ev_in=%h disp=%h time=%h exp=0", eq_ev_in, disp_data, sim_time);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL done_idle got=%b exp=1", done);
    end
  endtask

  task automatic test_insert_order();
    bit got;
    logic [1:0] cs_op;
    logic [31:0] ev;
    run = 1'b0;
    do_insert(32'hA000_0005, got, cs_op, ev);
    total++;
    if (!got || cs_op !== 2'b11 || ev !== 32'hA000_0005) begin
      bad++; $display("FAIL insert5 got=%0d cs_op=%b ev=%h exp cs_op=11 ev=a0000005", got, cs_op, ev);
    end
    do_insert(32'hB000_0003, got, cs_op, ev);
    total++;
    if (!got || cs_op !== 2'b11 || ev !== 32'hB000_0003) begin
      bad++; $display("FAIL insert3 got=%0d cs_op=%b ev=%h exp cs_op=11 ev=b0000003", got, cs_op, ev);
    end
    run = 1'b1;
    wait_disp(got);
    total++;
    if (!got || disp_data !== 32'hB000_0003 || sim_time !== 16'd3) begin
      bad++; $display("FAIL order_first got=%h time=%0d exp=b0000003 time=3", disp_data, sim_time);
    end
    accept();
    wait_disp(got);
    total++;
    if (!got || disp_data !== 32'hA000_0005 || sim_time !== 16'd5 || err !== 1'b0) begin
      bad++; $display("FAIL order_second got=%h time=%0d err=%b exp=a0000005 time=5 err=0", disp_data, sim_time, err);
    end
    run = 1'b0;
    accept();
    total++;
    if (disp_valid !== 1'b0) begin
      bad++; $display("FAIL accept_clears got=%b exp=0", disp_valid);
    end
  endtask

  task automatic test_priority();
    bit got;
    logic [1:0] cs_op;
    logic [31:0] ev;
    do_insert(32'hC000_000A, got, cs_op, ev);
    @(negedge clk);
    run = 1'b1;
    ins_valid = 1'b1;
    ins_data = 32'hD000_000B;
    @(negedge clk);
    total++;
    if ({ins_ready, eq_cs, eq_op} !== 3'b111) begin
      bad++; $display("FAIL prio_wr_first got=%b exp=111", {ins_ready, eq_cs, eq_op});
    end
    ins_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({ins_ready, eq_cs, eq_op} !== 3'b010) begin
      bad++; $display("FAIL prio_rd_next got=%b exp=010", {ins_ready, eq_cs, eq_op});
    end
    wait_disp(got);
    total++;
    if (!got || disp_data !== 32'hC000_000A || sim_time !== 16'd10) begin
      bad++; $display("FAIL prio_disp got=%h time=%0d exp=c000000a time=10", disp_data, sim_time);
    end
    run = 1'b0;
    accept();
  endtask

  task automatic test_causality();
    bit got;
    logic [1:0] cs_op;
    logic [31:0] ev;
    do_insert(32'hE000_0007, got, cs_op, ev);
    total++;
    if (!got || err !== 1'b1) begin
      bad++; $display("FAIL causal_err got=%b exp=1", err);
    end
    run = 1'b1;
    wait_disp(got);
    total++;
    if (!got || disp_data !== 32'hE000_0007 || sim_time !== 16'd10 || err !== 1'b1) begin
      bad++; $display("FAIL causal_disp got=%h time=%0d err=%b exp=e0000007 time=10 err=1", disp_data, sim_time, err);
    end
    accept();
    wait_disp(got);
    total++;
    if (!got || disp_data !== 32'hD000_000B || sim_time !== 16'd11) begin
      bad++; $display("FAIL causal_next got=%h time=%0d exp=d000000b time=11", disp_data, sim_time);
    end
    run = 1'b0;
    accept();
    total++;
    if (err !== 1'b1) begin
      bad++; $display("FAIL err_sticky got=%b exp=1", err);
    end
  endtask

  task automatic test_backpressure();
    full_force = 1'b1;
    ins_valid = 1'b1;
    ins_data = 32'hF000_000C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (ins_ready !== 1'b0 || eq_cs !== 1'b0) begin
        bad++; $display("FAIL full_stall cycle=%0d ready=%b cs=%b exp 0 0", i, ins_ready, eq_cs);
      end
    end
    full_force = 1'b0;
    @(negedge clk);
    total++;
    if ({ins_ready, eq_cs, eq_op} !== 3'b111 || eq_ev_in !== 32'hF000_000C) begin
      bad++; $display("FAIL full_release got=%b ev=%h exp=111 ev=f000000c", {ins_ready, eq_cs, eq_op}, eq_ev_in);
    end
    ins_valid = 1'b0;
  endtask

  task automatic test_hold_stable();
    bit got;
    run = 1'b1;
    wait_disp(got);
    total++;
    if (!got || disp_data !== 32'hF000_000C || sim_time !== 16'd12) begin
      bad++; $display("FAIL hold_disp got=%h time=%0d exp=f000000c time=12", disp_data, sim_time);
    end
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (disp_valid !== 1'b1 || disp_data !== 32'hF000_000C) begin
        bad++; $display("FAIL hold_stable cycle=%0d valid=%b data=%h exp 1 f000000c", i, disp_valid, disp_data);
      end
    end
    accept();
    total++;
    if (disp_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release got=%b exp=0", disp_valid);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin
      bad++; $display("FAIL done_drained got=%b exp=1", done);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit got;
    logic [1:0] cs_op;
    logic [31:0] ev;
    withhold = 1'b1;
    do_insert(32'h1234_0028, got, cs_op, ev);
    run = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (eq_cs === 1'b1 && eq_op === 1'b0) got = 1;
    end
    total++;
    if (!got) begin
      bad++; $display("FAIL midwait_rd got=%b exp=1", got);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({eq_cs, eq_op, ins_ready, disp_valid, err, done} !== 6'b0 || sim_time !== 16'h0 ||
        eq_ev_in !== 32'h0 || disp_data !== 32'h0) begin
      bad++; $display("FAIL midwait_reset got=%b time=%h ev=%h disp=%h exp all 0",
                      {eq_cs, eq_op, ins_ready, disp_valid, err, done}, sim_time, eq_ev_in, disp_data);
    end
    withhold = 1'b0;
    run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

`ifdef EVDISP_DV_TIMEOUT_EN
  task automatic test_dv_timeout();
    bit got;
    logic [1:0] cs_op;
    logic [31:0] ev;
    withhold = 1'b1;
    do_insert(32'h5555_0032, got, cs_op, ev);
    run = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (eq_cs === 1'b1 && eq_op === 1'b0) got = 1;
    end
    run = 1'b0;
    for (int i = 0; i < 17; i++) @(negedge clk);
    total++;
    if (!got || err !== 1'b1 || eq_cs !== 1'b0 || disp_valid !== 1'b0 || sim_time !== 16'h0) begin
      bad++; $display("FAIL dv_timeout err=%b cs=%b valid=%b time=%h exp 1 0 0 0", err, eq_cs, disp_valid, sim_time);
    end
    withhold = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    run = 1'b0;
    ins_valid = 1'b0;
    ins_data = '0;
    disp_ready = 1'b0;
    test_reset();
    test_insert_order();
    test_priority();
    test_causality();
    test_backpressure();
    test_hold_stable();
    test_reset_mid_wait();
`ifdef EVDISP_DV_TIMEOUT_EN
    test_dv_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
